// File: rtl/data_memory_ctrl.sv
// ============================================================================
// data_memory_ctrl
// ----------------------------------------------------------------------------
// Data memory for the RISC-V MEM stage. A valid/ready request channel feeds a
// byte-enabled word array (block-RAM style, registered read), a memory-mapped
// LED register and an illegal-access detector. Each accepted access produces
// exactly one registered response pulse.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req_valid      request present
//   req_ready      block can accept a request this cycle (IDLE only)
//   address        byte address (ADDR_W bits)
//   D_in           store data; SB/SH take the low bits
//   read_write_en  [3]=load, [2:0]=op (LB LBU LH LHU LW SB SH SW = 000..111)
//   rsp_valid      one-cycle pulse marking a completed access
//   D_out          formatted load data, valid with rsp_valid, 0 otherwise
//   fault          valid with rsp_valid: the access was illegal
//   led            current LED register contents
//
// Build option
//   MISALIGN_CHECK_EN  when defined, LH/LHU/SH with address[0]=1 and LW/SW
//                      with address[1:0]!=0 are illegal. When undefined the
//                      offset bits an op does not use are simply ignored.
//
// Timing
//   Writes (RAM and LED) commit at the accept edge. A load accepted at edge N
//   reads the array at N, is formatted at N+1 and answered after N+2. Stores,
//   no-ops and illegal accesses are answered after N+1.
// ============================================================================
module data_memory_ctrl #(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] LED_ADDR    = ADDR_W'(32'h0000_8000),
    parameter int                LED_W       = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       D_in,
    input  logic [3:0]        read_write_en,
    output logic              rsp_valid,
    output logic [31:0]       D_out,
    output logic              fault,
    output logic [LED_W-1:0]  led
);

    localparam int              IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] RAM_BYTES = (ADDR_W+1)'(4 * DEPTH_WORDS);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    // ------------------------------------------------------------------
    // Word array, power-up contents word[i] = i (never reset)
    // ------------------------------------------------------------------
    typedef logic [31:0] mem_t [DEPTH_WORDS];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            m[i] = 32'(i);
        end
        return m;
    endfunction

    mem_t mem_reg = mem_init();

    // Sign/zero extension of the byte or half selected by the byte offset.
    function automatic logic [31:0] format_load(input logic [31:0] w,
                                                input logic [2:0]  op,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_off;
    logic [2:0]       op;
    logic             is_load;
    logic             in_ram;
    logic             is_led;
    logic             is_store_op;
    logic             bad_op;
    logic             misalign;
    logic             illegal;
    logic             accept;
    logic             ram_we;
    logic             led_we;
    logic [3:0]       byte_en;
    logic [31:0]      wdata;

    assign word_idx    = address[IDX_W+1:2];
    assign byte_off    = address[1:0];
    assign op          = read_write_en[2:0];
    assign is_load     = read_write_en[3];
    assign in_ram      = {1'b0, address} < RAM_BYTES;
    assign is_led      = address[ADDR_W-1:2] == LED_ADDR[ADDR_W-1:2];
    // Only ops 101..111 with the load bit clear are stores; the remaining
    // store-side encodings are harmless no-ops.
    assign is_store_op = !is_load && op[2] && (op[1] || op[0]);
    assign bad_op      =  is_load && op[2] && (op[1] || op[0]);

`ifdef MISALIGN_CHECK_EN
    logic half_acc;
    logic word_acc;
    assign half_acc = (is_load && (op == OP_LH || op == OP_LHU)) || (!is_load && op == OP_SH);
    assign word_acc = (is_load && op == 3'b100) || (!is_load && op == OP_SW);
    assign misalign = (half_acc && byte_off[0]) || (word_acc && (byte_off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign illegal = bad_op || !(in_ram || is_led) || misalign;
    assign accept  = req_valid && req_ready;
    assign ram_we  = accept && !illegal && is_store_op && in_ram;
    assign led_we  = accept && !illegal && is_store_op && is_led;

    // Per-lane enables and write data. Narrow stores replicate their data
    // across lanes so each lane can pick its bits without a shifter.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_en[gi] = ((op == OP_SB) && (byte_off == 2'(gi)))
                           || ((op == OP_SH) && (byte_off[1] == (gi >= 2)))
                           ||  (op == OP_SW);
        assign wdata[gi*8 +: 8] = (op == OP_SB) ? D_in[7:0]
                                : (op == OP_SH) ? D_in[(gi % 2)*8 +: 8]
                                :                 D_in[gi*8 +: 8];
    end

    // ------------------------------------------------------------------
    // RAM port: write and registered read share the accept edge
    // ------------------------------------------------------------------
    logic [31:0] rd_word_reg;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_reg[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (accept) begin
            rd_word_reg <= mem_reg[word_idx];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, RESP = 2'd2} state_t;

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (is_load && !illegal) ? RD : RESP;
                end
            end
            RD:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath: latched request, formatted data, registered response
    // ------------------------------------------------------------------
    logic [2:0]       op_reg;
    logic [1:0]       off_reg;
    logic             led_sel_reg;
    logic             fault_pend_reg;
    logic [31:0]      fmt_reg;
    logic             rsp_valid_reg;
    logic [31:0]      d_out_reg;
    logic             fault_out_reg;
    logic [LED_W-1:0] led_reg;
    logic [31:0]      load_src;

    // LED loads see the register zero-extended to a full word.
    assign load_src = led_sel_reg ? 32'(led_reg) : rd_word_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg         <= '0;
            off_reg        <= '0;
            led_sel_reg    <= 1'b0;
            fault_pend_reg <= 1'b0;
            fmt_reg        <= '0;
            rsp_valid_reg  <= 1'b0;
            d_out_reg      <= '0;
            fault_out_reg  <= 1'b0;
            led_reg        <= '0;
        end else begin
            if (accept) begin
                op_reg         <= op;
                off_reg        <= byte_off;
                led_sel_reg    <= is_led;
                fault_pend_reg <= illegal;
                // Stores and faults answer with zero data.
                fmt_reg        <= '0;
            end
            if (led_we) begin
                led_reg <= D_in[LED_W-1:0];
            end
            if (state_reg == RD) begin
                fmt_reg <= format_load(load_src, op_reg, off_reg);
            end
            rsp_valid_reg <= (state_reg == RESP);
            d_out_reg     <= (state_reg == RESP) ? fmt_reg : 32'd0;
            fault_out_reg <= (state_reg == RESP) && fault_pend_reg;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign D_out     = d_out_reg;
    assign fault     = fault_out_reg;
    assign led       = led_reg;

endmodule
